z80_mmu: RTL and testbench
==========================

# z80_mmu

Parametrised Z80 memory-management unit. It splits the 16-bit CPU address into 2^WINDOW_BITS windows, each relocated through an I/O-programmable page register onto a PHYS_WIDTH-bit system bus. It also inserts a per-window programmable number of wait states and hands the bus to a DMA master during bus acknowledge. It sits between the CPU core and the system bus, and generalises the fixed 2-bit page / 22-bit bus-address split.

## Interface
- WINDOW_BITS, 2: log2 of window count NW; offset width OW = 16-WINDOW_BITS.
- PHYS_WIDTH, 22: system bus address width; page width PW = PHYS_WIDTH-OW (must be 1..8).
- WAIT_BITS, 2: width of each per-window wait-state register.
- IO_BASE, 8'h78: first I/O port of the register block.

- i_clk  in  1  system clock; same clock as the CPU.
- i_reset  in  1  synchronous, active-high reset.
- i_addr  in  16  CPU address bus.
- i_data  in  8  CPU write data.
- i_mreq_n, i_iorq_n, i_rd_n, i_wr_n, i_m1_n, i_rfsh_n  in  1 each  CPU control strobes.
- i_busack_n  in  1  low = DMA owns the bus.
- i_dma_addr  in  PHYS_WIDTH  DMA physical address.
- o_bus_addr  out  PHYS_WIDTH  physical address to the system bus.
- o_data  out  8  register readback data.
- o_data_oe  out  1  drive o_data onto the CPU data bus.
- o_wait_n  out  1  to CPU nWAIT.

## Operation
- Register map (port = i_addr[7:0]):
  - IO_BASE+i, i<NW: PAGE[i], PW bits.
  - IO_BASE+NW+i: WAIT[i], WAIT_BITS bits.
  - IO_BASE+2NW: CTRL; bit0 = EN.
  - Unused data bits are ignored on write and read back as 0.
- I/O write: io_wr = !i_iorq_n & !i_wr_n & i_m1_n.
  - The register is committed on the first clock where io_wr is high (prev io_wr low), using i_data sampled in that cycle.
  - Exactly one commit per I/O cycle.
  - Writes to out-of-range ports are ignored.
- I/O read: o_data_oe = !i_iorq_n & !i_rd_n & i_m1_n & port in range, combinational.
  - o_data = addressed register, zero-extended; o_data = 0 when o_data_oe is low.
  - Interrupt acknowledge (M1 with IORQ) never decodes.
- Address mapping, combinational. Window w = i_addr[15:OW].
  - i_busack_n low: o_bus_addr = i_dma_addr.
  - EN=1: o_bus_addr = {PAGE[w], i_addr[OW-1:0]}.
  - EN=0: o_bus_addr = zero-extended i_addr.
- Wait-state FSM, IDLE/WAIT, counter cnt of WAIT_BITS bits:
  - mem_start = !i_mreq_n & i_rfsh_n & prev_mreq_n (registered i_mreq_n).
  - IDLE: on mem_start with WAIT[w] != 0, load cnt = WAIT[w]-1. Go to WAIT if the loaded value != 0, otherwise stay in IDLE.
  - WAIT: cnt decrements each clock; go to IDLE when cnt reaches 0.
  - o_wait_n = !(mem_start & WAIT[w]!=0) & state==IDLE.
  - Net effect: o_wait_n is low for exactly WAIT[w] consecutive clocks, starting in the mem_start cycle.
  - Refresh cycles (i_rfsh_n low) and I/O cycles never insert waits.
  - When EN=0, WAIT[w] still applies.
- Reset values:
  - PAGE[i] = i, so setting EN reproduces the identity map.
  - WAIT[i] = 0, EN = 0, state IDLE, cnt = 0, prev_mreq_n = 1, prev io_wr = 0.

## Timing
- o_bus_addr, o_data and o_data_oe are combinational from inputs and registers; zero latency.
- A register write is visible to mapping and readback on the clock after commit.
  - A write to the PAGE register of the currently executing window remaps the next access only.
- Simultaneous mem_start and register commit: mem_start uses the old WAIT value.
- i_busack_n low: FSM forced to IDLE, cnt cleared, o_wait_n high in the same cycle. mem_start is suppressed while DMA owns the bus.
- i_reset high: o_wait_n forced high in the same cycle; all state takes its reset value at the next edge, including when asserted mid-WAIT or mid-I/O-write.
- Back-to-back memory cycles: a new mem_start is only possible after MREQ deasserts, so the FSM is always IDLE by then.

## Test plan
- After reset, EN=0: i_addr=16'hC123 -> o_bus_addr=22'h00C123; reading port 8'h7B -> o_data=8'h03 with o_data_oe=1.
- OUT 8'h7B,8'hA5, then OUT 8'h80,1 (defaults) -> i_addr=16'hC123 gives o_bus_addr=22'h29_4123 (PAGE 8'hA5, offset 14'h0123).
- OUT 8'h7D,2 (WAIT[1]=2), then memory read at 16'h4000 -> o_wait_n low exactly 2 clocks starting at the MREQ-fall cycle; refresh with the same address -> no wait.
- During WAIT with cnt=1, drop i_busack_n -> o_wait_n high immediately, o_bus_addr=i_dma_addr, and the FSM is IDLE afterwards.
- An I/O write held active for 4 clocks with data changing after the first clock -> only first-clock data committed; an interrupt-acknowledge cycle on port 8'h78 -> no commit, o_data_oe=0.
- Assert i_reset mid-WAIT after programming PAGE/EN -> o_wait_n high that cycle; afterwards PAGE[i]=i, EN=0, and all WAIT registers read 0.

Source files
------------

// File: rtl/z80_mmu.sv
// z80_mmu: relocates 16-bit Z80 addresses through per-window page registers onto a wider bus,
// inserts per-window wait states and hands the bus to a DMA master during bus acknowledge.
module z80_mmu #(
  parameter int WINDOW_BITS = 2,
  parameter int PHYS_WIDTH = 22,
  parameter int WAIT_BITS = 2,
  parameter logic [7:0] IO_BASE = 8'h78
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [15:0]           i_addr,
  input  logic [7:0]            i_data,
  input  logic                  i_mreq_n,
  input  logic                  i_iorq_n,
  input  logic                  i_rd_n,
  input  logic                  i_wr_n,
  input  logic                  i_m1_n,
  input  logic                  i_rfsh_n,
  input  logic                  i_busack_n,
  input  logic [PHYS_WIDTH-1:0] i_dma_addr,
  output logic [PHYS_WIDTH-1:0] o_bus_addr,
  output logic [7:0]            o_data,
  output logic                  o_data_oe,
  output logic                  o_wait_n
);
  localparam int NW = 1 << WINDOW_BITS;
  localparam int OW = 16 - WINDOW_BITS;
  localparam int PW = PHYS_WIDTH - OW;
  localparam logic [7:0] NW8 = 8'(NW);
  localparam logic [7:0] CTRL8 = 8'(2 * NW);
  typedef enum logic {IDLE, WAITING} state_t;
  state_t state, state_n;
  logic [WAIT_BITS-1:0] cnt, cnt_n, wait_w;
  logic [PW-1:0] page [NW];
  logic [WAIT_BITS-1:0] wt [NW];
  logic en, prev_io_wr, prev_mreq_n;
  logic [8:0] diff;
  logic [7:0] idx, rd_val;
  logic [WINDOW_BITS-1:0] w, sel;
  logic in_range, io_wr, commit, mem_start, wait_req;
  // NW is a power of two, so the low index bits select the entry in both the PAGE and WAIT banks
  assign diff = {1'b0, i_addr[7:0]} - {1'b0, IO_BASE};
  assign idx = diff[7:0];
  assign sel = idx[WINDOW_BITS-1:0];
  assign in_range = !diff[8] && idx <= CTRL8;
  assign io_wr = !i_iorq_n & !i_wr_n & i_m1_n;
  assign commit = io_wr & !prev_io_wr & in_range;
  assign o_data_oe = !i_iorq_n & !i_rd_n & i_m1_n & in_range;
  assign rd_val = idx < NW8 ? 8'(page[sel]) : idx < CTRL8 ? 8'(wt[sel]) : {7'b0, en};
  assign o_data = o_data_oe ? rd_val : '0;
  assign w = i_addr[15:OW];
  assign wait_w = wt[w];
  assign o_bus_addr = !i_busack_n ? i_dma_addr : en ? {page[w], i_addr[OW-1:0]} : PHYS_WIDTH'(i_addr);
  assign mem_start = !i_mreq_n & i_rfsh_n & prev_mreq_n & i_busack_n;
  assign wait_req = mem_start & (wait_w != '0);
  assign o_wait_n = i_reset | !i_busack_n | (!wait_req & state == IDLE);
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NW; i++) begin
        page[i] <= PW'(i);
        wt[i] <= '0;
      end
      en <= 1'b0;
      prev_io_wr <= 1'b0;
      prev_mreq_n <= 1'b1;
    end else begin
      prev_io_wr <= io_wr;
      prev_mreq_n <= i_mreq_n;
      if (commit) begin
        if (idx < NW8) page[sel] <= i_data[PW-1:0];
        else if (idx < CTRL8) wt[sel] <= i_data[WAIT_BITS-1:0];
        else en <= i_data[0];
      end
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (!i_busack_n) begin
      state_n = IDLE;
      cnt_n = '0;
    end else if (state == IDLE) begin
      if (wait_req) begin
        cnt_n = wait_w - WAIT_BITS'(1);
        state_n = cnt_n != '0 ? WAITING : IDLE;
      end
    end else begin
      cnt_n = cnt - WAIT_BITS'(1);
      state_n = cnt_n == '0 ? IDLE : WAITING;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
endmodule

// File: tb/tb_z80_mmu.sv
// tb_z80_mmu: directed vector tables plus hand sequences for wait, DMA, I/O-hold and reset corners.
module tb_z80_mmu;
  logic clk = 0, reset;
  logic [15:0] addr;
  logic [7:0] data;
  logic mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n, busack_n;
  logic [21:0] dma_addr, bus_addr;
  logic [7:0] odata;
  logic oe, wait_n;
  int checks = 0, errors = 0;
  typedef struct {
    logic [15:0] addr;
    logic iorq_n, rd_n, m1_n, busack_n;
    logic [21:0] dma, exp_bus;
    logic [7:0] exp_data;
    logic exp_oe;
  } vec_t;
  vec_t t1 [10];
  vec_t t2 [8];
  z80_mmu dut (
    .i_clk(clk), .i_reset(reset), .i_addr(addr), .i_data(data),
    .i_mreq_n(mreq_n), .i_iorq_n(iorq_n), .i_rd_n(rd_n), .i_wr_n(wr_n),
    .i_m1_n(m1_n), .i_rfsh_n(rfsh_n), .i_busack_n(busack_n), .i_dma_addr(dma_addr),
    .o_bus_addr(bus_addr), .o_data(odata), .o_data_oe(oe), .o_wait_n(wait_n)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic idle();
    mreq_n = 1; iorq_n = 1; rd_n = 1; wr_n = 1; m1_n = 1; rfsh_n = 1; busack_n = 1;
  endtask
  task automatic io_write(input logic [7:0] port, input logic [7:0] d);
    addr = {8'h00, port}; data = d; iorq_n = 0; wr_n = 0;
    step();
    idle();
    step();
  endtask
  task automatic io_read(input string name, input logic [7:0] port, input logic [7:0] exp);
    addr = {8'h00, port}; iorq_n = 0; rd_n = 0;
    #1;
    check({name, "_oe"}, 32'(oe), 32'd1);
    check(name, 32'(odata), 32'(exp));
    idle();
    step();
  endtask
  task automatic run_table(input vec_t v, input int n);
    addr = v.addr; iorq_n = v.iorq_n; rd_n = v.rd_n; m1_n = v.m1_n;
    busack_n = v.busack_n; dma_addr = v.dma;
    #1;
    check($sformatf("vec%0d_bus", n), 32'(bus_addr), 32'(v.exp_bus));
    check($sformatf("vec%0d_data", n), 32'(odata), 32'(v.exp_data));
    check($sformatf("vec%0d_oe", n), 32'(oe), 32'(v.exp_oe));
    idle();
    #1;
  endtask
  initial begin
    //          addr      iorq rd m1 back dma         bus         data  oe
    t1[0] = '{16'hC123, 1, 1, 1, 1, 22'h0,      22'h00C123, 8'h00, 0};
    t1[1] = '{16'h007B, 0, 0, 1, 1, 22'h0,      22'h00007B, 8'h03, 1};
    t1[2] = '{16'h0078, 0, 0, 1, 1, 22'h0,      22'h000078, 8'h00, 1};
    t1[3] = '{16'h127A, 0, 0, 1, 1, 22'h0,      22'h00127A, 8'h02, 1};
    t1[4] = '{16'h007C, 0, 0, 1, 1, 22'h0,      22'h00007C, 8'h00, 1};
    t1[5] = '{16'h0080, 0, 0, 1, 1, 22'h0,      22'h000080, 8'h00, 1};
    t1[6] = '{16'h0081, 0, 0, 1, 1, 22'h0,      22'h000081, 8'h00, 0};
    t1[7] = '{16'h0077, 0, 0, 1, 1, 22'h0,      22'h000077, 8'h00, 0};
    t1[8] = '{16'h0078, 0, 0, 0, 1, 22'h0,      22'h000078, 8'h00, 0};
    t1[9] = '{16'hC123, 1, 1, 1, 0, 22'h3ABCDE, 22'h3ABCDE, 8'h00, 0};
    t2[0] = '{16'hC123, 1, 1, 1, 1, 22'h0,      22'h294123, 8'h00, 0};
    t2[1] = '{16'h0000, 1, 1, 1, 1, 22'h0,      22'h000000, 8'h00, 0};
    t2[2] = '{16'h4567, 1, 1, 1, 1, 22'h0,      22'h004567, 8'h00, 0};
    t2[3] = '{16'h8ABC, 1, 1, 1, 1, 22'h0,      22'h008ABC, 8'h00, 0};
    t2[4] = '{16'hFFFF, 1, 1, 1, 1, 22'h0,      22'h297FFF, 8'h00, 0};
    t2[5] = '{16'h007B, 0, 0, 1, 1, 22'h0,      22'h00007B, 8'hA5, 1};
    t2[6] = '{16'h0080, 0, 0, 1, 1, 22'h0,      22'h000080, 8'h01, 1};
    t2[7] = '{16'hC123, 1, 1, 1, 0, 22'h155555, 22'h155555, 8'h00, 0};
    idle();
    reset = 1; addr = 0; data = 0; dma_addr = 0;
    step();
    step();
    check("reset_wait_n", 32'(wait_n), 32'd1);
    reset = 0;
    step();
    foreach (t1[i]) run_table(t1[i], i);
    step();
    io_write(8'h7B, 8'hA5);
    io_write(8'h80, 8'h01);
    foreach (t2[i]) run_table(t2[i], 100 + i);
    step();
    io_write(8'h79, 8'h3C);
    addr = 16'h4000;
    #1;
    check("page1_remap", 32'(bus_addr), 32'h0F0000);
    addr = 16'h0078; data = 8'h11; iorq_n = 0; wr_n = 0;
    #1;
    check("pre_commit_bus", 32'(bus_addr), 32'h000078);
    step();
    check("post_commit_bus", 32'(bus_addr), 32'h044078);
    idle();
    step();
    io_write(8'h7D, 8'h02);
    addr = 16'h4000; mreq_n = 0; rd_n = 0;
    #1;
    check("w2_c0", 32'(wait_n), 32'd0);
    step();
    check("w2_c1", 32'(wait_n), 32'd0);
    step();
    check("w2_c2", 32'(wait_n), 32'd1);
    idle();
    step();
    mreq_n = 0; rfsh_n = 0;
    #1;
    check("rfsh_c0", 32'(wait_n), 32'd1);
    step();
    check("rfsh_c1", 32'(wait_n), 32'd1);
    idle();
    step();
    addr = 16'h0100; mreq_n = 0; rd_n = 0;
    #1;
    check("w0_c0", 32'(wait_n), 32'd1);
    idle();
    step();
    io_write(8'h7E, 8'h01);
    addr = 16'h8000; mreq_n = 0; rd_n = 0;
    #1;
    check("w1_c0", 32'(wait_n), 32'd0);
    step();
    check("w1_c1", 32'(wait_n), 32'd1);
    idle();
    step();
    addr = 16'h407D; data = 8'h03; mreq_n = 0; iorq_n = 0; wr_n = 0;
    #1;
    check("simul_c0", 32'(wait_n), 32'd0);
    step();
    iorq_n = 1; wr_n = 1;
    check("simul_c1", 32'(wait_n), 32'd0);
    step();
    check("simul_old_wait", 32'(wait_n), 32'd1);
    idle();
    step();
    io_read("wait1_rb", 8'h7D, 8'h03);
    addr = 16'h4000; mreq_n = 0; rd_n = 0;
    step();
    step();
    check("dma1_wait_before", 32'(wait_n), 32'd0);
    busack_n = 0; dma_addr = 22'h2AAAAA;
    #1;
    check("dma1_wait_n", 32'(wait_n), 32'd1);
    check("dma1_bus", 32'(bus_addr), 32'h2AAAAA);
    step();
    busack_n = 1;
    #1;
    check("dma1_after", 32'(wait_n), 32'd1);
    idle();
    step();
    addr = 16'h4000; mreq_n = 0; rd_n = 0;
    step();
    busack_n = 0;
    #1;
    check("dma2_wait_n", 32'(wait_n), 32'd1);
    step();
    busack_n = 1;
    #1;
    check("dma2_forced_idle", 32'(wait_n), 32'd1);
    idle();
    step();
    addr = 16'h007A; data = 8'h5A; iorq_n = 0; wr_n = 0;
    step();
    for (int k = 0; k < 3; k++) begin
      data = 8'hF0 + 8'(k);
      step();
    end
    idle();
    step();
    io_read("hold_rb", 8'h7A, 8'h5A);
    addr = 16'h0078; data = 8'hEE; iorq_n = 0; m1_n = 0; wr_n = 0; rd_n = 0;
    #1;
    check("intack_oe", 32'(oe), 32'd0);
    check("intack_data", 32'(odata), 32'd0);
    step();
    idle();
    step();
    io_read("intack_no_commit", 8'h78, 8'h11);
    addr = 16'h4000; mreq_n = 0; rd_n = 0;
    step();
    check("rst_mid_wait_before", 32'(wait_n), 32'd0);
    reset = 1;
    #1;
    check("rst_wait_n", 32'(wait_n), 32'd1);
    step();
    reset = 0;
    idle();
    step();
    for (int k = 0; k < 9; k++)
      io_read($sformatf("rst_reg%0d", k), 8'h78 + 8'(k), k < 4 ? 8'(k) : 8'h00);
    addr = 16'hC123;
    #1;
    check("rst_identity", 32'(bus_addr), 32'h00C123);
    addr = 16'h4000; mreq_n = 0; rd_n = 0;
    #1;
    check("rst_no_wait", 32'(wait_n), 32'd1);
    idle();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
